controle_irrigacao: RTL and testbench

//  Clocked controller for the irrigation/water-tank system. Filters the raw soil, air and

---
 rtl/controle_irrigacao_pkg.sv | 16 +
 rtl/debounce_filtro.sv | 55 +++++
 rtl/controle_irrigacao.sv | 178 +++++++++++++++++
 tb/tb_controle_irrigacao.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/controle_irrigacao_pkg.sv
// rtl/controle_irrigacao_pkg.sv - shared state encoding and default parameters for controle_irrigacao
package controle_irrigacao_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GOTEJ = 2'd1;
    localparam logic [1:0] ST_ASPER = 2'd2;
    localparam logic [1:0] ST_FALHA = 2'd3;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int MIN_ON_CYCLES_DEF   = 1000;
    localparam int DISPLAY_CYCLES_DEF  = 500;
    localparam int CW_DEF              = 16;

endpackage

// File: rtl/debounce_filtro.sv
// rtl/debounce_filtro.sv - 2-flop synchronizer followed by a stability-counter debounce
module debounce_filtro
    import controle_irrigacao_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CW              = CW_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive synced samples that disagree with the filtered value;
    // any agreeing sample restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer chain and filter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/controle_irrigacao.sv
// rtl/controle_irrigacao.sv - irrigation/tank controller top; CONTROLE_SEL_MANUAL_EN selects manual display page
module controle_irrigacao
    import controle_irrigacao_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int MIN_ON_CYCLES   = MIN_ON_CYCLES_DEF,
    parameter int DISPLAY_CYCLES  = DISPLAY_CYCLES_DEF,
    parameter int CW              = CW_DEF
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               UmidadeAr,
    input  logic               UmidadeSolo,
    input  logic               Temperatura,
    input  logic               High,
    input  logic               Medium,
    input  logic               Low,
`ifdef CONTROLE_SEL_MANUAL_EN
    input  logic               ChaveSeletora,
`endif
    output logic               Gotejamento,
    output logic               Aspersao,
    output logic               ValvulaEntrada,
    output logic               Erro,
    output logic               Alarme,
    output logic               DisplaySel,
    output logic [STATE_W-1:0] Estado
);

    localparam logic [CW-1:0] MIN_ON = CW'(MIN_ON_CYCLES);

    // Bit order: 0 Ar, 1 Solo, 2 Temp, 3 Low, 4 Medium, 5 High
    logic [5:0] raw;
    logic [5:0] filt;

    assign raw = {High, Medium, Low, Temperatura, UmidadeSolo, UmidadeAr};

    for (genvar g = 0; g < 6; g++) begin : g_filtro
        debounce_filtro #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_filtro (
            .clk_i (Clock),
            .rst_ni(Reset_n),
            .raw_i (raw[g]),
            .filt_o(filt[g])
        );
    end

    logic f_ar, f_solo, f_temp, f_low, f_med, f_high;
    assign f_ar   = filt[0];
    assign f_solo = filt[1];
    assign f_temp = filt[2];
    assign f_low  = filt[3];
    assign f_med  = filt[4];
    assign f_high = filt[5];

    logic erro_d, alarme_d, d_got, d_asp;
    logic erro_q, alarme_q;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CW-1:0]      on_cnt_q, on_cnt_d;
    logic               got_q, asp_q;
    logic               valve_q, valve_d;

    // Level consistency and demand decode from filtered sensors.
    always_comb begin
        erro_d   = (f_high & ~f_med) | (f_med & ~f_low);
        alarme_d = ~f_low | erro_d;
        d_got    = ~f_solo & f_ar & (~f_med | f_temp);
        d_asp    = ~f_solo & (~f_ar | (f_med & ~f_temp));
    end

    // Mode FSM; alarm preempts everything including the minimum on-time.
    always_comb begin
        state_d  = state_q;
        on_cnt_d = on_cnt_q;
        if (alarme_d) begin
            state_d = ST_FALHA;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (d_asp) begin
                        state_d  = ST_ASPER;
                        on_cnt_d = '0;
                    end else if (d_got) begin
                        state_d  = ST_GOTEJ;
                        on_cnt_d = '0;
                    end
                end
                ST_GOTEJ, ST_ASPER: begin
                    if (on_cnt_q == MIN_ON &&
                        !((state_q == ST_GOTEJ) ? d_got : d_asp)) begin
                        state_d = ST_IDLE;
                    end else if (on_cnt_q != MIN_ON) begin
                        on_cnt_d = on_cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Inlet valve hysteresis; an error closes it on the same edge it is flagged.
    always_comb begin
        valve_d = valve_q;
        if (erro_d || f_high) begin
            valve_d = 1'b0;
        end else if (!f_med) begin
            valve_d = 1'b1;
        end
    end

    // State, actuators, valve and status registers share one update edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            on_cnt_q <= '0;
            got_q    <= 1'b0;
            asp_q    <= 1'b0;
            valve_q  <= 1'b0;
            erro_q   <= 1'b0;
            alarme_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            on_cnt_q <= on_cnt_d;
            got_q    <= (state_d == ST_GOTEJ);
            asp_q    <= (state_d == ST_ASPER);
            valve_q  <= valve_d;
            erro_q   <= erro_d;
            alarme_q <= alarme_d;
        end
    end

`ifdef CONTROLE_SEL_MANUAL_EN
    logic sel_sync1_q, sel_sync2_q;

    // Page follows the operator switch through a 2-flop synchronizer.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_sync1_q <= 1'b0;
            sel_sync2_q <= 1'b0;
        end else begin
            sel_sync1_q <= ChaveSeletora;
            sel_sync2_q <= sel_sync1_q;
        end
    end

    assign DisplaySel = sel_sync2_q;
`else
    localparam logic [CW-1:0] DISP_LAST = CW'(DISPLAY_CYCLES - 1);

    logic [CW-1:0] disp_cnt_q;
    logic          disp_q;

    // Free-running page timer; page flips each time the counter wraps.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            disp_cnt_q <= '0;
            disp_q     <= 1'b0;
        end else if (disp_cnt_q == DISP_LAST) begin
            disp_cnt_q <= '0;
            disp_q     <= ~disp_q;
        end else begin
            disp_cnt_q <= disp_cnt_q + CW'(1);
        end
    end

    assign DisplaySel = disp_q;
`endif

    assign Gotejamento    = got_q;
    assign Aspersao       = asp_q;
    assign ValvulaEntrada = valve_q;
    assign Erro           = erro_q;
    assign Alarme         = alarme_q;
    assign Estado         = state_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// tb/tb_controle_irrigacao.sv - directed self-checking bench for controle_irrigacao
module tb_controle_irrigacao;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       UmidadeAr = 1'b0, UmidadeSolo = 1'b0, Temperatura = 1'b0;
    logic       High = 1'b0, Medium = 1'b0, Low = 1'b0;
`ifdef CONTROLE_SEL_MANUAL_EN
    logic       ChaveSeletora = 1'b0;
`endif
    logic       Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, DisplaySel;
    logic [1:0] Estado;

    int passed = 0;
    int total  = 0;

    controle_irrigacao #(
        .DEBOUNCE_CYCLES(4),
        .MIN_ON_CYCLES  (8),
        .DISPLAY_CYCLES (5),
        .CW             (16)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .UmidadeAr     (UmidadeAr),
        .UmidadeSolo   (UmidadeSolo),
        .Temperatura   (Temperatura),
        .High          (High),
        .Medium        (Medium),
        .Low           (Low),
`ifdef CONTROLE_SEL_MANUAL_EN
        .ChaveSeletora (ChaveSeletora),
`endif
        .Gotejamento   (Gotejamento),
        .Aspersao      (Aspersao),
        .ValvulaEntrada(ValvulaEntrada),
        .Erro          (Erro),
        .Alarme        (Alarme),
        .DisplaySel    (DisplaySel),
        .Estado        (Estado)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        tick(3);
        total++; if ({Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, DisplaySel, Estado} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000", {Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, DisplaySel, Estado}); else passed++;
        Reset_n = 1'b1;
        tick(1);
        total++; if (Estado !== 2'd3) $display("FAIL post_reset_falha: got %0d expected 3", Estado); else passed++;
        total++; if (Alarme !== 1'b1) $display("FAIL post_reset_alarme: got %b expected 1", Alarme); else passed++;
        total++; if (ValvulaEntrada !== 1'b1) $display("FAIL post_reset_valve: got %b expected 1", ValvulaEntrada); else passed++;
`ifndef CONTROLE_SEL_MANUAL_EN
        tick(3);
        total++; if (DisplaySel !== 1'b0) $display("FAIL disp_cycle4: got %b expected 0", DisplaySel); else passed++;
        tick(1);
        total++; if (DisplaySel !== 1'b1) $display("FAIL disp_cycle5: got %b expected 1", DisplaySel); else passed++;
        tick(5);
        total++; if (DisplaySel !== 1'b0) $display("FAIL disp_cycle10: got %b expected 0", DisplaySel); else passed++;
`endif
    endtask

    task automatic test_filter();
        Low = 1'b1; Medium = 1'b1; High = 1'b0;
        UmidadeAr = 1'b1; Temperatura = 1'b1; UmidadeSolo = 1'b1;
        tick(12);
        total++; if (Estado !== 2'd0) $display("FAIL settle_idle: got %0d expected 0", Estado); else passed++;
        total++; if (Alarme !== 1'b0 || Erro !== 1'b0) $display("FAIL settle_alarm: got %b%b expected 00", Alarme, Erro); else passed++;
        UmidadeSolo = 1'b0;
        tick(3);
        UmidadeSolo = 1'b1;
        tick(15);
        total++; if (Gotejamento !== 1'b0) $display("FAIL short_pulse: got %b expected 0", Gotejamento); else passed++;
        UmidadeSolo = 1'b0;
        tick(6);
        total++; if (Gotejamento !== 1'b0) $display("FAIL filt_early: got %b expected 0", Gotejamento); else passed++;
        tick(1);
        total++; if (Gotejamento !== 1'b1 || Estado !== 2'd1) $display("FAIL gotej_enter: got %b/%0d expected 1/1", Gotejamento, Estado); else passed++;
    endtask

    task automatic test_min_on();
        UmidadeSolo = 1'b1;
        tick(7);
        total++; if (Gotejamento !== 1'b1) $display("FAIL min_on_7: got %b expected 1", Gotejamento); else passed++;
        tick(1);
        total++; if (Gotejamento !== 1'b1) $display("FAIL min_on_8: got %b expected 1", Gotejamento); else passed++;
        tick(1);
        total++; if (Gotejamento !== 1'b0 || Estado !== 2'd0) $display("FAIL min_on_exit: got %b/%0d expected 0/0", Gotejamento, Estado); else passed++;
    endtask

    task automatic test_erro();
        UmidadeSolo = 1'b0;
        tick(7);
        total++; if (Estado !== 2'd1) $display("FAIL erro_pre_gotej: got %0d expected 1", Estado); else passed++;
        High = 1'b1; Medium = 1'b0; UmidadeSolo = 1'b1;
        tick(6);
        total++; if (Erro !== 1'b0 || Gotejamento !== 1'b1) $display("FAIL erro_early: got %b/%b expected 0/1", Erro, Gotejamento); else passed++;
        tick(1);
        total++; if ({Erro, Alarme, Estado, Gotejamento, ValvulaEntrada} !== 6'b111100)
            $display("FAIL erro_edge: got %b expected 111100", {Erro, Alarme, Estado, Gotejamento, ValvulaEntrada}); else passed++;
        High = 1'b0; Medium = 1'b1;
        tick(6);
        total++; if (Estado !== 2'd3) $display("FAIL erro_hold: got %0d expected 3", Estado); else passed++;
        tick(1);
        total++; if ({Erro, Alarme, Estado, ValvulaEntrada} !== 5'b00000)
            $display("FAIL erro_clear: got %b expected 00000", {Erro, Alarme, Estado, ValvulaEntrada}); else passed++;
    endtask

    task automatic test_valve();
        Low = 1'b0; Medium = 1'b0;
        tick(7);
        total++; if ({Alarme, Erro, ValvulaEntrada, Estado} !== 5'b10111)
            $display("FAIL empty_tank: got %b expected 10111", {Alarme, Erro, ValvulaEntrada, Estado}); else passed++;
        Low = 1'b1;
        tick(7);
        total++; if ({Alarme, ValvulaEntrada, Estado} !== 4'b0100) $display("FAIL low_rise: got %b expected 0100", {Alarme, ValvulaEntrada, Estado}); else passed++;
        Medium = 1'b1;
        tick(7);
        total++; if (ValvulaEntrada !== 1'b1) $display("FAIL med_rise_hold: got %b expected 1", ValvulaEntrada); else passed++;
        High = 1'b1;
        tick(6);
        total++; if (ValvulaEntrada !== 1'b1) $display("FAIL high_early: got %b expected 1", ValvulaEntrada); else passed++;
        tick(1);
        total++; if (ValvulaEntrada !== 1'b0 || Erro !== 1'b0) $display("FAIL high_close: got %b/%b expected 0/0", ValvulaEntrada, Erro); else passed++;
        High = 1'b0;
        tick(7);
        total++; if (ValvulaEntrada !== 1'b0) $display("FAIL high_fall_hold: got %b expected 0", ValvulaEntrada); else passed++;
        Medium = 1'b0;
        tick(7);
        total++; if (ValvulaEntrada !== 1'b1) $display("FAIL med_fall_open: got %b expected 1", ValvulaEntrada); else passed++;
    endtask

    task automatic test_back_to_back();
        Medium = 1'b1; UmidadeSolo = 1'b0;
        tick(6);
        total++; if (Estado !== 2'd0) $display("FAIL b2b_idle: got %0d expected 0", Estado); else passed++;
        tick(1);
        total++; if (Estado !== 2'd1 || Gotejamento !== 1'b1) $display("FAIL b2b_gotej: got %0d/%b expected 1/1", Estado, Gotejamento); else passed++;
        Temperatura = 1'b0;
        tick(8);
        total++; if (Estado !== 2'd1) $display("FAIL b2b_min_on: got %0d expected 1", Estado); else passed++;
        tick(1);
        total++; if ({Estado, Gotejamento, Aspersao} !== 4'b0000) $display("FAIL b2b_gap: got %b expected 0000", {Estado, Gotejamento, Aspersao}); else passed++;
        tick(1);
        total++; if ({Estado, Gotejamento, Aspersao} !== 4'b1001) $display("FAIL b2b_asper: got %b expected 1001", {Estado, Gotejamento, Aspersao}); else passed++;
    endtask

    task automatic test_reset_midrun();
        tick(2);
        #3;
        Reset_n = 1'b0;
        #1;
        total++; if ({Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, DisplaySel, Estado} !== 8'h00)
            $display("FAIL async_reset: got %b expected 00000000", {Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, DisplaySel, Estado}); else passed++;
        tick(2);
        total++; if ({Aspersao, Estado} !== 3'b000) $display("FAIL reset_held: got %b expected 000", {Aspersao, Estado}); else passed++;
        Reset_n = 1'b1;
        tick(4);
`ifndef CONTROLE_SEL_MANUAL_EN
        total++; if (DisplaySel !== 1'b0) $display("FAIL rst2_disp4: got %b expected 0", DisplaySel); else passed++;
`endif
        tick(1);
`ifndef CONTROLE_SEL_MANUAL_EN
        total++; if (DisplaySel !== 1'b1) $display("FAIL rst2_disp5: got %b expected 1", DisplaySel); else passed++;
`endif
        total++; if (Estado !== 2'd3 || Aspersao !== 1'b0) $display("FAIL rst2_state: got %0d/%b expected 3/0", Estado, Aspersao); else passed++;
    endtask

`ifdef CONTROLE_SEL_MANUAL_EN
    task automatic test_manual_sel();
        ChaveSeletora = 1'b1;
        tick(1);
        total++; if (DisplaySel !== 1'b0) $display("FAIL sel_lat1: got %b expected 0", DisplaySel); else passed++;
        tick(1);
        total++; if (DisplaySel !== 1'b1) $display("FAIL sel_lat2: got %b expected 1", DisplaySel); else passed++;
        ChaveSeletora = 1'b0;
        tick(2);
        total++; if (DisplaySel !== 1'b0) $display("FAIL sel_back: got %b expected 0", DisplaySel); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_filter();
        test_min_on();
        test_erro();
        test_valve();
        test_back_to_back();
        test_reset_midrun();
`ifdef CONTROLE_SEL_MANUAL_EN
        test_manual_sel();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
